// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU host-link front end: UART FSM states and packet sizing.
package gpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned PKT_BYTES_DEF = 60;
  localparam int unsigned IDX_W         = 7;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, bit timer, FSM and LSB-first shift register.
// With IA_TIMEOUT_EN defined an extra idle_o output reports the FSM sitting in idle.
module uart_rx_byte
  import gpu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
`ifdef IA_TIMEOUT_EN
  output logic       idle_o,
`endif
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       stop_err_o
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] HalfM1 = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] FullM1 = TimerW'(CLKS_PER_BIT - 1);

  logic              rx_meta_q, rxs_q;
  uart_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;

  // Sync flops preset high so reset looks like an idle line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= StIdle;
      timer_q   <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TimerW'(1);
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    stop_err_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfM1) begin
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = rxs_q ? StIdle : StData;
        end
      end
      StData: begin
        if (timer_q == FullM1) begin
          timer_d  = '0;
          shift_d  = {rxs_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (timer_q == FullM1) begin
          timer_d      = '0;
          state_d      = StIdle;
          byte_valid_o = rxs_q;
          stop_err_o   = !rxs_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign byte_o = shift_q;
`ifdef IA_TIMEOUT_EN
  assign idle_o = (state_q == StIdle);
`endif

endmodule

// File: rtl/ia_uart_rx.sv
// Host packet receiver: tags each good UART byte with its packet index and flags packet completion.
// Define IA_TIMEOUT_EN to resync the packet index to 0 after a long inter-byte idle.
module ia_uart_rx
  import gpu_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned PKT_BYTES = PKT_BYTES_DEF
`ifdef IA_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_BITS = 20
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [7:0]       read_data,
  output logic [IDX_W-1:0] idx,
  output logic             update_reg,
  output logic             pc_ready,
  output logic             frame_err
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0]       byte_w;
  logic             byte_valid, stop_err;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       read_data_q, read_data_d;
  logic             update_q, frame_err_q, pc_pend_q, pc_ready_q;
  logic             last_byte;

`ifdef IA_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * ClksPerBit;
  localparam int unsigned IdleW         = $clog2(TimeoutCycles + 1);

  logic             line_idle, timeout_hit;
  logic [IdleW-1:0] idle_q, idle_d;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(ClksPerBit)
  ) u_byte (
    .clk_i       (clk),
    .rst_i       (reset),
    .rx_i        (rx),
`ifdef IA_TIMEOUT_EN
    .idle_o      (line_idle),
`endif
    .byte_o      (byte_w),
    .byte_valid_o(byte_valid),
    .stop_err_o  (stop_err)
  );

`ifdef IA_TIMEOUT_EN
  // Runs only mid-packet; any start edge leaves idle and clears it.
  always_comb begin
    idle_d      = '0;
    timeout_hit = 1'b0;
    if (line_idle && count_q != '0) begin
      if (idle_q == IdleW'(TimeoutCycles - 1)) timeout_hit = 1'b1;
      else idle_d = idle_q + IdleW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  always_comb begin
    last_byte   = (count_q == IDX_W'(PKT_BYTES - 1));
    count_d     = count_q;
    idx_d       = idx_q;
    read_data_d = read_data_q;
    if (byte_valid) begin
      count_d     = last_byte ? '0 : count_q + IDX_W'(1);
      idx_d       = count_q;
      read_data_d = byte_w;
    end
`ifdef IA_TIMEOUT_EN
    if (timeout_hit) count_d = '0;
`endif
  end

  // pc_ready trails the final update_reg by one cycle so the two never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      idx_q       <= '0;
      read_data_q <= '0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
      pc_pend_q   <= 1'b0;
      pc_ready_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      idx_q       <= idx_d;
      read_data_q <= read_data_d;
      update_q    <= byte_valid;
      frame_err_q <= stop_err;
      pc_pend_q   <= byte_valid & last_byte;
      pc_ready_q  <= pc_pend_q;
    end
  end

  assign read_data  = read_data_q;
  assign idx        = idx_q;
  assign update_reg = update_q;
  assign frame_err  = frame_err_q;
  assign pc_ready   = pc_ready_q;

endmodule
